// File: rtl/count_pwm_gen_pkg.sv
// Shared constants for the counter-driven PWM generator.
// State encoding and a small helper used by the top level.
package count_pwm_gen_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    function automatic logic is_busy(input logic [1:0] st);
        return st != ST_IDLE;
    endfunction

endpackage

// File: rtl/count_pwm_gen_duty_shadow_reg.sv
// Duty shadow register: one pending slot behind a valid/ready
// handshake, promoted to the active duty only on a period start.
import count_pwm_gen_pkg::*;

module count_pwm_gen_duty_shadow_reg #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_duty,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [N-1:0] o_duty_next
);

    logic [N-1:0] r_pending;
    logic         r_pending_full;
    logic [N-1:0] r_active;
    logic         w_xfer;
    logic         w_promote;

    assign o_ready   = ~r_pending_full;
    assign w_xfer    = i_valid & o_ready;
    assign w_promote = i_load & r_pending_full;

    // No bypass: a value accepted on a start edge waits for the next start.
    assign o_duty_next = w_promote ? r_pending : r_active;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_active       <= '0;
        end else if (w_promote) begin
            r_active       <= r_pending;
            r_pending_full <= 1'b0;
        end else if (w_xfer) begin
            r_pending      <= i_duty;
            r_pending_full <= 1'b1;
        end
    end

endmodule

// File: rtl/count_pwm_gen.sv
// PWM stage fed by a free-running counter: start detect, run FSM,
// registered pwm_out and period_done.
import count_pwm_gen_pkg::*;

module count_pwm_gen #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         rst,
    input  logic [N-1:0] count,
    input  logic         enable,
    input  logic [N-1:0] duty_in,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic         pwm_out,
    output logic         period_done,
    output logic         busy
);

    logic [N-1:0] r_prev_count;
    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic         w_start;
    logic         w_load;
    logic         w_run_any;
    logic [N-1:0] w_duty_next;

    // Also fires when the upstream counter is reset mid-period.
    assign w_start = (count == '0) && (r_prev_count != '0);
    assign w_load  = w_start && is_busy(r_state);
    assign busy    = is_busy(r_state);

    count_pwm_gen_duty_shadow_reg #(.N(N)) u_shadow (
        .clock       (clock),
        .rst         (rst),
        .i_load      (w_load),
        .i_duty      (duty_in),
        .i_valid     (duty_valid),
        .o_ready     (duty_ready),
        .o_duty_next (w_duty_next)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (enable) w_state_next = ST_ARM;
            ST_ARM: begin
                if (!enable)      w_state_next = ST_IDLE;
                else if (w_start) w_state_next = ST_RUN;
            end
            ST_RUN:  if (!enable) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_run_any = (r_state == ST_RUN) || (w_state_next == ST_RUN);

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_prev_count <= '0;
            pwm_out      <= 1'b0;
            period_done  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_prev_count <= count;
            pwm_out      <= w_run_any && (count < w_duty_next);
            period_done  <= (r_state == ST_RUN) && w_start && enable;
        end
    end

endmodule

// File: tb/tb_count_pwm_gen.sv
// Scoreboard bench for count_pwm_gen with an upstream 8-bit counter.
module tb_count_pwm_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       cnt_rst;
    logic [7:0] r_cnt = 8'd0;
    logic       enable;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_done;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit pwm;
        bit done;
        bit rdy;
        bit bsy;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: mode 0 idle, 1 armed, 2 running.
    int m_mode = 0;
    int m_act  = 0;
    int m_prev = 0;
    int m_pend[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_rst) r_cnt <= 8'd0;
        else         r_cnt <= r_cnt + 8'd1;
    end

    count_pwm_gen #(.N(8)) dut (
        .clock       (clk),
        .rst         (rst),
        .count       (r_cnt),
        .enable      (enable),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .busy        (busy)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, req, $time);
        end
    endtask

    // Model: decides the expected post-edge outputs from pre-edge inputs.
    always @(posedge clk) begin : model
        int   c;
        int   nm;
        bit   wrap;
        bit   acc;
        exp_t e;
        e = '{0, 0, 1, 0};
        if (rst) begin
            m_mode = 0;
            m_act  = 0;
            m_prev = 0;
            m_pend.delete();
        end else begin
            c    = int'(r_cnt);
            wrap = (c == 0) && (m_prev != 0);
            acc  = duty_valid && (m_pend.size() == 0);
            if (!enable)          nm = 0;
            else if (m_mode == 0) nm = 1;
            else if (wrap)        nm = 2;
            else                  nm = m_mode;
            if (wrap && m_mode != 0 && m_pend.size() > 0)
                m_act = m_pend.pop_front();
            if (acc) m_pend.push_back(int'(duty_in));
            e.pwm  = ((m_mode == 2) || (nm == 2)) && (c < m_act);
            e.done = (m_mode == 2) && wrap && enable;
            m_mode = nm;
            m_prev = c;
        end
        e.rdy = (m_pend.size() == 0);
        e.bsy = (m_mode != 0);
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pwm_out",     int'(pwm_out),     int'(e.pwm));
            chk("period_done", int'(period_done), int'(e.done));
            chk("duty_ready",  int'(duty_ready),  int'(e.rdy));
            chk("busy",        int'(busy),        int'(e.bsy));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_count(input int v);
        int k = 0;
        while (int'(r_cnt) != v && k < 600) begin
            cycle();
            k++;
        end
        if (k >= 600) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_count: got %0d expected %0d", r_cnt, v);
        end
    endtask

    task automatic offer(input int d);
        duty_in    = 8'(d);
        duty_valid = 1'b1;
        cycle();
        duty_valid = 1'b0;
    endtask

    // Steady state at one duty: any 256-cycle window holds exactly d highs.
    task automatic window(input string nm, input int d);
        int hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out) hi++;
        end
        chk(nm, hi, d);
    endtask

    initial begin
        rst        = 1'b1;
        cnt_rst    = 1'b1;
        enable     = 1'b0;
        duty_in    = 8'd0;
        duty_valid = 1'b0;
        run(3);
        cnt_rst = 1'b0;
        run(2);
        rst = 1'b0;

        // Reset mid-period while running with a pending value
        enable = 1'b1;
        offer(77);
        wait_count(0);
        run(1);
        offer(33);
        wait_count(50);
        rst = 1'b1;
        enable = 1'b0;
        run(2);
        rst = 1'b0;
        run(3);

        // Duty 64 from ARM into RUN
        offer(64);
        enable = 1'b1;
        run(600);
        window("win_duty64", 64);

        // Load 200 mid-period at count 100
        cycle();
        wait_count(100);
        offer(200);
        run(300);
        window("win_duty200", 200);

        // Transfer on the start edge itself
        cycle();
        wait_count(0);
        offer(10);
        run(600);
        window("win_duty10", 10);

        // Duty bounds
        offer(0);
        run(600);
        window("win_duty0", 0);
        cycle();
        offer(255);
        run(600);
        window("win_duty255", 255);

        // Disable mid-period, re-enable, upstream counter reset at 150
        cycle();
        wait_count(128);
        enable = 1'b0;
        run(5);
        enable = 1'b1;
        run(400);
        wait_count(150);
        cnt_rst = 1'b1;
        cycle();
        cnt_rst = 1'b0;
        run(300);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            duty_valid = ($urandom_range(0, 7) == 0);
            duty_in    = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            cnt_rst = ($urandom_range(0, 399) == 0);
            rst     = ($urandom_range(0, 999) == 0);
            cycle();
        end
        duty_valid = 1'b0;
        cnt_rst    = 1'b0;
        rst        = 1'b0;
        run(4);
        @(negedge clk);
        #1;
        chk("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
